bcd_seq_ctrl: RTL
=================

Name: bcd_seq_ctrl

Overview:
- Multi-cycle sequencer for the calculator's binary-to-BCD conversion path, using the shift-and-add-3 (double dabble) method.
- Processes one input bit per clock with a start/busy/done handshake.
- Handles signed operands by converting to magnitude plus a sign flag.
- Detects results that do not fit the display digits and saturates them.
- Sits between the ALU result register and the 7-segment digit drivers.

Parameters:
- WIDTH, 32, bit width of the binary operand (>= 4).
- DIGITS, 3, number of BCD output digits (1..10); digit 0 is units.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- _input  input  WIDTH  operand; captured on the accepting edge.
- is_signed  input  1  1 = treat _input as two's complement; captured with _input.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid from this cycle.
- bcd_out  output  4*DIGITS  digit k at bits [4k+3:4k]; held until the next done.
- negative  output  1  result sign; held with bcd_out.
- overflow  output  1  magnitude > 10^DIGITS-1; held with bcd_out.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, negative=0, overflow=0, all working registers 0.
- States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE: on the edge where start=1, register _input and is_signed, then go to LOAD. start=0 stays in IDLE.
- LOAD (1 cycle):
  - If is_signed=1 and _input[WIDTH-1]=1: mag = ~_input + 1 (WIDTH bits, unsigned) and neg_w=1.
  - Otherwise mag = _input and neg_w=0.
  - Clear the BCD shift register (4*DIGITS bits), the ovf sticky flag and the bit counter.
  - Most-negative operand: mag = 2^(WIDTH-1), interpreted as unsigned. No special case.
- SHIFT (exactly WIDTH cycles, counter 0..WIDTH-1). Each cycle, in order:
  1. Every digit >= 5 gets +3.
  2. If bit 3 of the top digit is 1 after step 1, set ovf (sticky).
  3. Shift {bcd, mag} left by 1; the MSB of mag enters bit 0 of the BCD register.
  - After the counter reaches WIDTH-1, go to DONE.
- DONE (1 cycle):
  - done=1.
  - bcd_out = ovf ? all digits 4'd9 : the BCD register.
  - negative = neg_w, except that a zero result forces negative=0.
  - overflow = ovf.
  - All three outputs update on the edge entering DONE and are stable while done=1.
  - Next state is IDLE.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0+WIDTH+1. For WIDTH=32, done rises on the 34th edge counting E0 as edge 1.
- Back-to-back throughput: one result per WIDTH+3 cycles. start must be high in IDLE; start during LOAD, SHIFT or DONE is ignored and is not queued.
- Input stability: changes on _input or is_signed after acceptance do not affect the running conversion.
- Reset mid-operation: immediate return to IDLE with every output at its reset value. No done is issued for the aborted conversion.
- busy is combinational from the state register (no glitch-prone input path). done is registered.

Test Plan:
- Unsigned 255: _input=32'd255, is_signed=0, start pulse -> done exactly 34 edges after acceptance; bcd_out=12'h255, negative=0, overflow=0; busy high from LOAD through DONE.
- Signed -123: _input=32'hFFFFFF85, is_signed=1 -> bcd_out=12'h123, negative=1, overflow=0. The same pattern with is_signed=0 -> overflow=1, bcd_out=12'h999, negative=0.
- Boundaries: 999 -> 12'h999, overflow=0. 1000 -> 12'h999, overflow=1. 0 -> 12'h000, negative=0. Signed 32'h80000000 -> overflow=1, negative=1.
- Ignored start: start held high continuously with 5 then 7 applied -> first result 5. The second conversion starts only on the edge after done (in IDLE) and yields 7; _input changed mid-conversion has no effect.
- Reset mid-conversion: assert reset 10 cycles after start -> outputs zero immediately (asynchronous), no done pulse. A later start with 42 -> 12'h042 with normal latency.
- Parameter sweep: WIDTH=8, DIGITS=3 with all 256 unsigned values and all signed values compared against a reference model; done latency = 10 edges.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_seq_ctrl
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) for
//   the calculator display path. One operand bit is consumed per clock.
//   Signed operands are converted to magnitude + sign; results that do not
//   fit in DIGITS decimal digits saturate to all nines with overflow set.
//
// Handshake (valid/ready style):
//   start is sampled only while the FSM is IDLE (busy=0); the edge where
//   start=1 and busy=0 accepts _input/is_signed. start at any other time is
//   ignored and not queued. done is a one-cycle pulse marking the cycle in
//   which bcd_out/negative/overflow first carry the new result; those outputs
//   then hold until the next done or reset.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      conversion request (sampled in IDLE only)
//   _input     operand, WIDTH bits
//   is_signed  1 = _input is two's complement
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle result pulse (registered)
//   bcd_out    DIGITS BCD digits, digit k at [4k+3:4k], digit 0 = units
//   negative   result sign (forced 0 for a zero result)
//   overflow   magnitude exceeded 10^DIGITS-1 (bcd_out saturated to 9s)
//   state_dbg  current FSM state (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
// ---------------------------------------------------------------------------
module bcd_seq_ctrl #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      _input,
   input  logic                  is_signed,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  negative,
   output logic                  overflow,
   output logic [1:0]            state_dbg
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]          state;
   logic [WIDTH-1:0]    in_q;
   logic                sgn_q;
   logic [WIDTH-1:0]    mag;
   logic [4*DIGITS-1:0] bcd;
   logic                ovf;
   logic                neg_w;
   logic [CW-1:0]       cnt;

   logic [4*DIGITS-1:0] bcd_adj;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic [WIDTH-1:0]    mag_nxt;
   logic                ovf_nxt;
   logic [4*DIGITS-1:0] bcd_final;
   logic                result_zero;

   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   // One double-dabble step: add 3 to every digit >= 5, then shift.
   // A top digit >= 8 after the add would lose its MSB on the shift, which is
   // exactly the case where the value no longer fits in DIGITS digits.
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5)
            bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      ovf_nxt     = ovf | bcd_adj[4*DIGITS-1];
      bcd_nxt     = {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
      mag_nxt     = {mag[WIDTH-2:0], 1'b0};
      bcd_final   = ovf_nxt ? {DIGITS{4'h9}} : bcd_nxt;
      result_zero = (bcd_nxt == '0) && !ovf_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         in_q     <= '0;
         sgn_q    <= 1'b0;
         mag      <= '0;
         bcd      <= '0;
         ovf      <= 1'b0;
         neg_w    <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         bcd_out  <= '0;
         negative <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  in_q  <= _input;
                  sgn_q <= is_signed;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               // The most-negative operand negates to itself, which read as
               // unsigned is the correct magnitude 2^(WIDTH-1).
               if (sgn_q && in_q[WIDTH-1]) begin
                  mag   <= (~in_q) + WIDTH'(1);
                  neg_w <= 1'b1;
               end else begin
                  mag   <= in_q;
                  neg_w <= 1'b0;
               end
               bcd   <= '0;
               ovf   <= 1'b0;
               cnt   <= '0;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               bcd <= bcd_nxt;
               mag <= mag_nxt;
               ovf <= ovf_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  // Publish from the final step's values so the outputs are
                  // already valid in the cycle done is high.
                  done     <= 1'b1;
                  bcd_out  <= bcd_final;
                  negative <= neg_w && !result_zero;
                  overflow <= ovf_nxt;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
